// File: rtl/bus_bridge_slave_pkg.sv
// Shared definitions for the UART bus bridge (slave side).
//   - frame layout helpers: frame = {mode, data, addr}
//   - mode encodings carried in the frame MSB
//   - bridge FSM state encoding and UART receiver state encoding
package bus_bridge_slave_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Bit positions inside a command frame, derived from the bridged widths.
  function automatic int unsigned bb_mode_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

  function automatic int unsigned bb_data_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned bb_frame_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_TX_START = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_WAIT_RD  = 3'd4,
    ST_RESP     = 3'd5
  } bb_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/bus_bridge_slave_uart.sv
// UART transceiver used by the bridge: 8N1-style framing, LSB first.
// Ports:
//   clk, rstn          clock, async active-low reset
//   tx_en, tx_din      start sending tx_din (ignored while tx_busy)
//   tx_busy            high from the start bit through the stop bit
//   tx                 serial output, idles high
//   rx                 serial input
//   rx_dout, rx_ready  last received word; ready is a level that rises when a
//                      word completes and drops when the next start bit arrives
module bus_bridge_slave_uart
  import bus_bridge_slave_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 5208,
  parameter int unsigned TX_DATA_WIDTH    = 21,
  parameter int unsigned RX_DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     tx_en,
  input  logic [TX_DATA_WIDTH-1:0] tx_din,
  output logic                     tx_busy,
  output logic                     tx,
  input  logic                     rx,
  output logic [RX_DATA_WIDTH-1:0] rx_dout,
  output logic                     rx_ready
);

  localparam int unsigned CCW = $clog2(CLOCKS_PER_PULSE) + 1;
  localparam int unsigned TBW = $clog2(TX_DATA_WIDTH + 2);
  localparam int unsigned RBW = $clog2(RX_DATA_WIDTH + 1);
  localparam logic [CCW-1:0] CNT_LAST = CCW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CCW-1:0] CNT_HALF = CCW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [TBW-1:0] TX_LAST  = TBW'(TX_DATA_WIDTH + 1);
  localparam logic [RBW-1:0] RX_LAST  = RBW'(RX_DATA_WIDTH - 1);

  logic [TX_DATA_WIDTH+1:0] tx_sh;
  logic [CCW-1:0]           tx_cnt;
  logic [TBW-1:0]           tx_bits;

  // Shift register holds {stop, data, start}; shifting in ones leaves the line high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
    end else if (!tx_busy) begin
      if (tx_en) begin
        tx_sh   <= {1'b1, tx_din, 1'b0};
        tx_cnt  <= '0;
        tx_bits <= '0;
        tx_busy <= 1'b1;
      end
    end else if (tx_cnt == CNT_LAST) begin
      tx_cnt <= '0;
      tx_sh  <= {1'b1, tx_sh[TX_DATA_WIDTH+1:1]};
      if (tx_bits == TX_LAST) begin
        tx_busy <= 1'b0;
      end else begin
        tx_bits <= tx_bits + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign tx = tx_sh[0];

  logic                     rx_s1;
  logic                     rx_s2;
  uart_rx_state_e           rx_state;
  logic [CCW-1:0]           rx_cnt;
  logic [RBW-1:0]           rx_bits;
  logic [RX_DATA_WIDTH-1:0] rx_sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sh    <= '0;
      rx_dout  <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_ready <= 1'b0;
          end
        end
        RX_START: begin
          // Re-check the start bit at mid-bit to reject glitches.
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[RX_DATA_WIDTH-1:1]};
            if (rx_bits == RX_LAST) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bits <= rx_bits + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_dout  <= rx_sh;
              rx_ready <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_bridge_slave.sv
// Remote-facing end of the UART bus bridge. Accepts local bus requests,
// serialises each as a {mode, data, addr} UART frame to the far bridge master,
// and for reads holds ssplit until the returned byte (or a timeout) completes
// the read.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   smemaddr, smemwdata              request address / write data
//   smemwen, smemren                 write / read request (write wins if both)
//   sready                           idle, a request is accepted this cycle
//   smemrdata, srvalid               read data with one-cycle valid
//   ssplit                           remote read outstanding
//   timeout_err                      one-cycle pulse when a read times out
//   u_tx, u_rx                       UART lines to/from the far bridge master
module bus_bridge_slave
  import bus_bridge_slave_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH            = 12,
  parameter int unsigned           DATA_WIDTH            = 8,
  parameter int unsigned           UART_CLOCKS_PER_PULSE = 5208,
  parameter int unsigned           TIMEOUT_CYCLES        = 1000000,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA          = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] smemaddr,
  input  logic [DATA_WIDTH-1:0] smemwdata,
  input  logic                  smemwen,
  input  logic                  smemren,
  output logic                  sready,
  output logic [DATA_WIDTH-1:0] smemrdata,
  output logic                  srvalid,
  output logic                  ssplit,
  output logic                  timeout_err,
  output logic                  u_tx,
  input  logic                  u_rx
);

  localparam int unsigned FW       = bb_frame_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned MODE_BIT = bb_mode_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned DATA_LSB = bb_data_lsb(ADDR_WIDTH);
  localparam int unsigned CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  bb_state_e             state;
  logic [CW-1:0]         counter;
  logic                  u_en;
  logic [FW-1:0]         u_din;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] rx_dout;
  logic                  rx_ready;
  logic                  rx_ready_q;
  logic                  rx_rise;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_mode;

  always_comb begin
    u_din                     = '0;
    u_din[MODE_BIT]           = req_mode;
    u_din[MODE_BIT-1:DATA_LSB] = req_data;
    u_din[DATA_LSB-1:0]       = req_addr;
  end

  // rx_ready is a level; only its rising edge marks a fresh reply byte.
  assign rx_rise = rx_ready & ~rx_ready_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      sready      <= 1'b0;
      srvalid     <= 1'b0;
      ssplit      <= 1'b0;
      timeout_err <= 1'b0;
      smemrdata   <= '0;
      counter     <= '0;
      u_en        <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
      req_mode    <= MODE_READ;
      rx_ready_q  <= 1'b0;
    end else begin
      srvalid     <= 1'b0;
      timeout_err <= 1'b0;
      u_en        <= 1'b0;
      rx_ready_q  <= rx_ready;
      case (state)
        ST_IDLE: begin
          sready <= 1'b1;
          if (sready && (smemwen || smemren)) begin
            sready   <= 1'b0;
            req_addr <= smemaddr;
            req_mode <= smemwen ? MODE_WRITE : MODE_READ;
            req_data <= smemwen ? smemwdata : '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          u_en  <= 1'b1;
          state <= ST_TX_START;
        end
        ST_TX_START: begin
          if (tx_busy) state <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (!tx_busy) begin
            if (req_mode == MODE_WRITE) begin
              sready <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              ssplit  <= 1'b1;
              counter <= '0;
              state   <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          if (counter != '1) counter <= counter + 1'b1;
          // A reply landing on the timeout cycle still wins.
          if (rx_rise) begin
            smemrdata <= rx_dout;
            srvalid   <= 1'b1;
            ssplit    <= 1'b0;
            state     <= ST_RESP;
          end else if (counter == TO_LAST) begin
            smemrdata   <= TIMEOUT_DATA;
            timeout_err <= 1'b1;
            srvalid     <= 1'b1;
            ssplit      <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          sready <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bus_bridge_slave_uart #(
    .CLOCKS_PER_PULSE (UART_CLOCKS_PER_PULSE),
    .TX_DATA_WIDTH    (FW),
    .RX_DATA_WIDTH    (DATA_WIDTH)
  ) u_uart (
    .clk      (clk),
    .rstn     (rstn),
    .tx_en    (u_en),
    .tx_din   (u_din),
    .tx_busy  (tx_busy),
    .tx       (u_tx),
    .rx       (u_rx),
    .rx_dout  (rx_dout),
    .rx_ready (rx_ready)
  );

endmodule

// File: tb/tb_bus_bridge_slave.sv
module tb_bus_bridge_slave;

  localparam int CPP = 4;
  localparam int TO  = 50;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] smemaddr;
  logic [7:0]  smemwdata;
  logic        smemwen;
  logic        smemren;
  logic        sready;
  logic [7:0]  smemrdata;
  logic        srvalid;
  logic        ssplit;
  logic        timeout_err;
  logic        u_tx;
  logic        u_rx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sv_count = 0;
  int rxlat = 42;
  logic [20:0] frames[$];
  logic [20:0] mf;

  bus_bridge_slave #(
    .ADDR_WIDTH            (12),
    .DATA_WIDTH            (8),
    .UART_CLOCKS_PER_PULSE (CPP),
    .TIMEOUT_CYCLES        (TO),
    .TIMEOUT_DATA          (8'hFF)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .smemaddr    (smemaddr),
    .smemwdata   (smemwdata),
    .smemwen     (smemwen),
    .smemren     (smemren),
    .sready      (sready),
    .smemrdata   (smemrdata),
    .srvalid     (srvalid),
    .ssplit      (ssplit),
    .timeout_err (timeout_err),
    .u_tx        (u_tx),
    .u_rx        (u_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (srvalid === 1'b1) sv_count <= sv_count + 1;

  // Far-end UART receiver: decodes every frame sent on u_tx.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && u_tx === 1'b0) begin
        repeat (CPP / 2) @(negedge clk);
        for (int i = 0; i < 21; i++) begin
          repeat (CPP) @(negedge clk);
          mf[i] = u_tx;
        end
        repeat (CPP) @(negedge clk);
        frames.push_back(mf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [20:0] model_frame(input logic w, input logic [11:0] a, input logic [7:0] d);
    logic [20:0] f;
    f = 21'(a);
    if (w) f = f + (21'(d) << 12) + (21'd1 << 20);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    u_rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    u_rx = 1'b1;
    repeat (CPP) @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic r, input logic [11:0] a, input logic [7:0] d);
    int n = 0;
    while (sready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sready !== 1'b1) begin
      failures++;
      $display("FAIL issue_wait sready=%b required=1", sready);
    end
    smemwen = w; smemren = r; smemaddr = a; smemwdata = d;
    @(negedge clk);
    smemwen = 1'b0; smemren = 1'b0;
  endtask

  task automatic wait_frame(output logic [20:0] f, output logic ok);
    int n = 0;
    while (frames.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (frames.size() > 0) begin
      f = frames.pop_front();
      ok = 1'b1;
    end else begin
      f = 'x;
      ok = 1'b0;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (sready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_read(input logic [11:0] a, input logic send, input logic [7:0] rb, input int dly,
                         output int sp_cyc, output int st_cyc, output int sv_cyc,
                         output logic [7:0] rd, output logic te, output logic sp_at,
                         output logic sv_next, output logic sp_early,
                         output logic [20:0] fr, output logic ok);
    logic fok;
    int n;
    ok = 1'b1; st_cyc = -1; sv_cyc = -1; rd = 'x; te = 'x; sp_at = 'x; sv_next = 'x;
    issue(1'b0, 1'b1, a, 8'h00);
    sp_early = ssplit;
    n = 0;
    while (ssplit !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ssplit !== 1'b1) ok = 1'b0;
    sp_cyc = cyc;
    fork
      begin
        if (send) begin
          repeat (dly) @(negedge clk);
          st_cyc = cyc;
          send_byte(rb);
        end
      end
      begin
        int m = 0;
        while (srvalid !== 1'b1 && m < 200) begin
          @(negedge clk);
          m++;
        end
        if (srvalid !== 1'b1) ok = 1'b0;
        sv_cyc = cyc; rd = smemrdata; te = timeout_err; sp_at = ssplit;
        @(negedge clk);
        sv_next = srvalid;
      end
    join
    wait_frame(fr, fok);
    if (!fok) ok = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sready, srvalid, ssplit, timeout_err, smemrdata, u_tx} !== {4'b0000, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_vals got=%b%b%b%b %h tx=%b required=0000 00 tx=1",
               sready, srvalid, ssplit, timeout_err, smemrdata, u_tx);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (sready !== 1'b0) begin failures++; $display("FAIL reset_release_sready got=%b required=0", sready); end
    @(negedge clk);
    checks++;
    if (sready !== 1'b1) begin failures++; $display("FAIL reset_first_cycle_sready got=%b required=1", sready); end
  endtask

  task automatic test_write;
    int base, low;
    logic [20:0] f;
    logic ok;
    base = sv_count;
    issue(1'b1, 1'b0, 12'h123, 8'hA5);
    checks++;
    if (sready !== 1'b0) begin failures++; $display("FAIL write_sready_drop got=%b required=0", sready); end
    wait_ready(low);
    checks++;
    if (low < 23 * CPP + 1 || low > 23 * CPP + 8) begin
      failures++;
      $display("FAIL write_busy_len got=%0d required=%0d..%0d", low, 23 * CPP + 1, 23 * CPP + 8);
    end
    wait_frame(f, ok);
    checks++;
    if (!ok || f !== 21'h1A5123) begin failures++; $display("FAIL write_frame got=%h required=1a5123", f); end
    repeat (10) @(negedge clk);
    checks++;
    if (sv_count != base) begin failures++; $display("FAIL write_no_srvalid got=%0d required=0", sv_count - base); end
  endtask

  task automatic test_read;
    int sp, st, sv;
    logic [7:0] rd;
    logic te, spa, svn, spe, ok;
    logic [20:0] fr;
    do_read(12'h0F0, 1'b1, 8'h3C, 0, sp, st, sv, rd, te, spa, svn, spe, fr, ok);
    checks++;
    if (!ok || fr !== 21'h000F0) begin failures++; $display("FAIL read_frame got=%h ok=%b required=000f0", fr, ok); end
    checks++;
    if (spe !== 1'b0) begin failures++; $display("FAIL read_split_during_tx got=%b required=0", spe); end
    checks++;
    if (rd !== 8'h3C || te !== 1'b0) begin failures++; $display("FAIL read_data got=%h te=%b required=3c te=0", rd, te); end
    checks++;
    if (spa !== 1'b0 || svn !== 1'b0) begin
      failures++;
      $display("FAIL read_resp_shape split=%b next_valid=%b required=0 0", spa, svn);
    end
    rxlat = sv - st;
    checks++;
    if (rxlat < 9 * CPP || rxlat > 10 * CPP + 6) begin
      failures++;
      $display("FAIL read_rx_latency got=%0d required=%0d..%0d", rxlat, 9 * CPP, 10 * CPP + 6);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_timeout;
    int sp, st, sv, base;
    logic [7:0] rd;
    logic te, spa, svn, spe, ok;
    logic [20:0] fr;
    do_read(12'h2A0, 1'b0, 8'h00, 0, sp, st, sv, rd, te, spa, svn, spe, fr, ok);
    checks++;
    if (!ok || rd !== 8'hFF || te !== 1'b1) begin
      failures++;
      $display("FAIL timeout_data got=%h te=%b ok=%b required=ff te=1", rd, te, ok);
    end
    checks++;
    if (sv - sp != TO) begin failures++; $display("FAIL timeout_cycles got=%0d required=%0d", sv - sp, TO); end
    checks++;
    if (svn !== 1'b0 || spa !== 1'b0) begin
      failures++;
      $display("FAIL timeout_resp_shape next_valid=%b split=%b required=0 0", svn, spa);
    end
    base = sv_count;
    send_byte(8'h11);
    repeat (20) @(negedge clk);
    checks++;
    if (sv_count != base || ssplit !== 1'b0) begin
      failures++;
      $display("FAIL late_byte_discard srvalids=%0d split=%b required=0 0", sv_count - base, ssplit);
    end
  endtask

  task automatic test_both;
    int base, low;
    logic [20:0] f;
    logic ok;
    base = sv_count;
    issue(1'b1, 1'b1, 12'h001, 8'h77);
    wait_ready(low);
    wait_frame(f, ok);
    checks++;
    if (!ok || f !== 21'h177001) begin failures++; $display("FAIL both_frame got=%h required=177001", f); end
    repeat (60) @(negedge clk);
    checks++;
    if (sv_count != base || ssplit !== 1'b0 || frames.size() != 0) begin
      failures++;
      $display("FAIL both_no_read srvalids=%0d split=%b extra_frames=%0d required=0 0 0",
               sv_count - base, ssplit, frames.size());
    end
  endtask

  task automatic test_tie;
    int sp, st, sv, tie;
    logic [7:0] rd, rb;
    logic te, spa, svn, spe, ok, exp_reply;
    logic [20:0] fr;
    tie = TO - rxlat;
    for (int d = tie - 2; d <= tie + 2; d++) begin
      if (d >= 0) begin
        rb = 8'($urandom_range(0, 254));
        do_read(12'($urandom), 1'b1, rb, d, sp, st, sv, rd, te, spa, svn, spe, fr, ok);
        exp_reply = (d + rxlat <= TO);
        checks++;
        if (!ok || (exp_reply && (rd !== rb || te !== 1'b0 || sv != st + rxlat)) ||
            (!exp_reply && (rd !== 8'hFF || te !== 1'b1 || sv != sp + TO))) begin
          failures++;
          $display("FAIL tie_d%0d got=%h te=%b at=%0d required=%h te=%b at=%0d", d, rd, te, sv - sp,
                   exp_reply ? rb : 8'hFF, !exp_reply, exp_reply ? d + rxlat : TO);
        end
        repeat (10) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid;
    int low;
    logic [20:0] f;
    logic ok;
    issue(1'b1, 1'b0, 12'h456, 8'h99);
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({sready, srvalid, ssplit, timeout_err, smemrdata, u_tx} !== {4'b0000, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL midreset_vals got=%b%b%b%b %h tx=%b required=0000 00 tx=1",
               sready, srvalid, ssplit, timeout_err, smemrdata, u_tx);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (sready !== 1'b1) begin failures++; $display("FAIL midreset_sready got=%b required=1", sready); end
    repeat (120) @(negedge clk);
    frames.delete();
    issue(1'b1, 1'b0, 12'h2BC, 8'h5A);
    wait_ready(low);
    wait_frame(f, ok);
    checks++;
    if (!ok || f !== 21'h15A2BC) begin failures++; $display("FAIL midreset_next_write got=%h required=15a2bc", f); end
  endtask

  task automatic test_random;
    int sp, st, sv, low, base;
    logic [7:0] rd, rb, d;
    logic [11:0] a;
    logic te, spa, svn, spe, ok, w;
    logic [20:0] fr;
    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      d = 8'($urandom);
      if (w) begin
        base = sv_count;
        issue(1'b1, 1'b0, a, d);
        wait_ready(low);
        wait_frame(fr, ok);
        checks++;
        if (!ok || fr !== model_frame(1'b1, a, d) || sv_count != base) begin
          failures++;
          $display("FAIL rand_write%0d got=%h srvalids=%0d required=%h 0", i, fr, sv_count - base,
                   model_frame(1'b1, a, d));
        end
      end else begin
        rb = 8'($urandom);
        do_read(a, 1'b1, rb, $urandom_range(0, 3), sp, st, sv, rd, te, spa, svn, spe, fr, ok);
        checks++;
        if (!ok || fr !== model_frame(1'b0, a, d) || rd !== rb || te !== 1'b0) begin
          failures++;
          $display("FAIL rand_read%0d frame=%h data=%h te=%b required=%h %h 0", i, fr, rd, te,
                   model_frame(1'b0, a, d), rb);
        end
      end
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    rstn = 1'b0; smemaddr = '0; smemwdata = '0; smemwen = 1'b0; smemren = 1'b0; u_rx = 1'b1;
    @(negedge clk);
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_both;
    test_tie;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
